traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter: CNT_W, 8, width of the completed-cycle counter.
REQ-002 Parameter: MAX_DWELL, 16, maximum consecutive samples of one phase before stuck is flagged.
REQ-003 Port: clk  input  1  single clock; all sampling on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: red  input  1  observed red lamp.
REQ-006 Port: yellow  input  1  observed yellow lamp.
REQ-007 Port: green  input  1  observed green lamp.
REQ-008 Port: err_clr  input  1  clears the sticky error flags.
REQ-009 Port: phase  output  2  decoded phase: 0=RED, 1=RED_YEL, 2=GREEN, 3=YEL.
REQ-010 Port: phase_valid  output  1  high when the monitor is locked to a legal phase.
REQ-011 Port: seq_err  output  1  one-cycle pulse when a legal pattern arrives out of order.
REQ-012 Port: illegal  output  1  one-cycle pulse when the lamp pattern is not a legal pattern.
REQ-013 Port: err_sticky  output  1  set by any seq_err or illegal pulse; held until err_clr.
REQ-014 Port: stuck  output  1  level; phase held longer than MAX_DWELL samples.
REQ-015 Port: cycle_count  output  CNT_W  number of completed RED->RED_YEL->GREEN->YEL->RED cycles.

Function
REQ-016 Legal {red,yellow,green} patterns SHALL be 100=RED, 110=RED_YEL, 001=GREEN, 010=YEL; all other patterns (000, 011, 101, 111) are illegal.
REQ-017 FSM states SHALL be SYNC, RED, RED_YEL, GREEN, YEL; successor order RED->RED_YEL->GREEN->YEL->RED.
REQ-018 Inputs SHALL be sampled each rising clk edge; all outputs are registered and reflect the pattern sampled at that edge (one-cycle latency).
REQ-019 SYNC: legal pattern -> enter the matching state, no error; illegal pattern -> remain in SYNC, pulse illegal.
REQ-020 Locked state, pattern equals current phase -> stay, dwell counter increments.
REQ-021 Locked state, pattern equals successor -> advance, dwell counter reloads to 1, no error.
REQ-022 Locked state, legal non-successor pattern -> jump to the matching state, pulse seq_err, dwell reloads to 1; cycle_count not incremented.
REQ-023 Locked state, illegal pattern -> go to SYNC, pulse illegal, phase_valid low.
REQ-024 cycle_count SHALL increment only on a legal YEL->RED advance; it wraps modulo 2^CNT_W.
REQ-025 phase_valid SHALL be high in every state except SYNC; phase SHALL hold its last value while in SYNC.
REQ-026 err_sticky: err_clr clears it; if err_clr coincides with a new seq_err or illegal event, the flag SHALL end set.
REQ-027 Dwell counter SHALL saturate at MAX_DWELL+1; stuck asserts when it exceeds MAX_DWELL and deasserts on the first phase change or entry to SYNC.

Reset
REQ-028 rst high SHALL immediately force state=SYNC, phase=0, phase_valid=0, seq_err=0, illegal=0, err_sticky=0, stuck=0, cycle_count=0, dwell=0.
REQ-029 Reset asserted mid-sequence SHALL discard the current phase; the first legal pattern after release relocks with no seq_err.

Configuration
REQ-030 Macro TLM_DWELL_CHECK_EN: when defined, dwell counter and stuck logic per REQ-027 are present.
REQ-031 When TLM_DWELL_CHECK_EN is undefined, no dwell counter is built and stuck SHALL be tied to 0; all other behaviour is unchanged.

Verification
REQ-032 Reset release, drive 100,110,001,010 repeated 3 times then 100 -> phase follows 0,1,2,3, cycle_count=3, no error pulses.
REQ-033 Locked in GREEN, drive 100 -> seq_err pulses one cycle, phase=0, err_sticky=1, cycle_count unchanged.
REQ-034 Locked in RED_YEL, drive 111 -> illegal pulses, phase_valid=0; then 001 -> phase=2, phase_valid=1, no seq_err.
REQ-035 err_clr high on the same edge as an illegal event -> err_sticky=1; err_clr alone next cycle -> err_sticky=0.
REQ-036 With TLM_DWELL_CHECK_EN, MAX_DWELL=4, hold 001 for 6 samples -> stuck rises after sample 5, falls when 010 sampled; without macro stuck stays 0.
REQ-037 CNT_W=2, run 5 full cycles -> cycle_count=1 (wrap); assert rst mid-GREEN -> all outputs zero asynchronously.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp observations in, decoded phase and error status out
interface traffic_light_monitor_if #(parameter int CNT_W = 8);
  logic             red;
  logic             yellow;
  logic             green;
  logic             err_clr;
  logic [1:0]       phase;
  logic             phase_valid;
  logic             seq_err;
  logic             illegal;
  logic             err_sticky;
  logic             stuck;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    output red, yellow, green, err_clr,
    input  phase, phase_valid, seq_err, illegal, err_sticky, stuck, cycle_count
  );
  modport slave (
    input  red, yellow, green, err_clr,
    output phase, phase_valid, seq_err, illegal, err_sticky, stuck, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks lamp patterns against RED->RED_YEL->GREEN->YEL; TLM_DWELL_CHECK_EN adds stuck-phase detection
module traffic_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 16
) (
  input logic clk,
  input logic rst,
  traffic_light_monitor_if.slave bus
);
  typedef enum logic [2:0] {
    S_RED   = 3'd0,
    S_RY    = 3'd1,
    S_GREEN = 3'd2,
    S_YEL   = 3'd3,
    SYNC    = 3'd4
  } state_t;
  if (MAX_DWELL < 1) begin : g_bad_dwell
    $error("MAX_DWELL must be at least 1");
  end
  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             phase_valid_q, phase_valid_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal_q, illegal_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [2:0]       pat;
  logic             lgl, in_sync, same, wrap;
  logic [1:0]       pp, cur;
  assign pat     = {bus.red, bus.yellow, bus.green};
  assign in_sync = state_q == SYNC;
  assign cur     = state_q[1:0];
  // Decode the lamp pattern and compute the next state and registered outputs
  always_comb begin
    lgl           = pat == 3'b100 || pat == 3'b110 || pat == 3'b001 || pat == 3'b010;
    pp            = pat == 3'b100 ? 2'd0 : pat == 3'b110 ? 2'd1 : pat == 3'b001 ? 2'd2 : 2'd3;
    same          = lgl && !in_sync && pp == cur;
    wrap          = lgl && !in_sync && cur == 2'd3 && pp == 2'd0;
    state_d       = lgl ? state_t'({1'b0, pp}) : SYNC;
    phase_d       = lgl ? pp : phase_q;
    phase_valid_d = lgl;
    illegal_d     = !lgl;
    seq_err_d     = lgl && !in_sync && pp != cur && pp != cur + 2'd1;
    err_sticky_d  = (err_sticky_q && !bus.err_clr) || seq_err_d || illegal_d;
    cycle_count_d = cycle_count_q + CNT_W'(wrap);
  end
  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      phase_q       <= 2'd0;
      phase_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      illegal_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      seq_err_q     <= seq_err_d;
      illegal_q     <= illegal_d;
      err_sticky_q  <= err_sticky_d;
      cycle_count_q <= cycle_count_d;
    end
  end
`ifdef TLM_DWELL_CHECK_EN
  localparam int DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DWELL);
  logic [DW-1:0] dwell_q, dwell_d;
  logic          stuck_q, stuck_d;
  // Count consecutive samples of the current phase, saturating one past the limit
  always_comb begin
    dwell_d = !lgl ? '0 : same ? (dwell_q > DMAX ? dwell_q : dwell_q + 1'b1) : DW'(1);
    stuck_d = dwell_d > DMAX;
  end
  // Dwell and stuck registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      stuck_q <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      stuck_q <= stuck_d;
    end
  end
  assign bus.stuck = stuck_q;
`else
  assign bus.stuck = 1'b0;
`endif
  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.illegal     = illegal_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios for traffic_light_monitor (CNT_W=2, MAX_DWELL=4)
module tb_traffic_light_monitor;
`ifdef TLM_DWELL_CHECK_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  traffic_light_monitor_if #(.CNT_W(2)) bus ();
  traffic_light_monitor #(.CNT_W(2), .MAX_DWELL(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input logic [2:0] p, input logic clr);
    {bus.red, bus.yellow, bus.green} = p;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    {bus.red, bus.yellow, bus.green} = 3'b100;
    bus.err_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, bus.err_sticky, bus.stuck, bus.cycle_count} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 000000000", {bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, bus.err_sticky, bus.stuck, bus.cycle_count});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_normal_cycle;
    logic [2:0] pats [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) begin
        step(pats[i], 1'b0);
        tests++;
        if ({bus.phase, bus.phase_valid, bus.seq_err, bus.illegal} !== {i[1:0], 3'b100}) begin
          fails++;
          $display("FAIL normal_r%0d_i%0d got phase=%0d v=%b se=%b il=%b want phase=%0d v=1 se=0 il=0", r, i, bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, i);
        end
      end
    step(3'b100, 1'b0);
    tests++;
    if ({bus.phase, bus.cycle_count, bus.err_sticky} !== {2'd0, 2'd3, 1'b0}) begin
      fails++;
      $display("FAIL normal_final got phase=%0d cnt=%0d sticky=%b want phase=0 cnt=3 sticky=0", bus.phase, bus.cycle_count, bus.err_sticky);
    end
  endtask

  task automatic test_seq_err;
    step(3'b110, 1'b0);
    step(3'b001, 1'b0);
    step(3'b100, 1'b0);
    tests++;
    if ({bus.seq_err, bus.phase, bus.err_sticky, bus.cycle_count, bus.illegal} !== {1'b1, 2'd0, 1'b1, 2'd3, 1'b0}) begin
      fails++;
      $display("FAIL seq_err_jump got se=%b phase=%0d sticky=%b cnt=%0d il=%b want se=1 phase=0 sticky=1 cnt=3 il=0", bus.seq_err, bus.phase, bus.err_sticky, bus.cycle_count, bus.illegal);
    end
    step(3'b110, 1'b0);
    tests++;
    if ({bus.seq_err, bus.err_sticky, bus.phase} !== {1'b0, 1'b1, 2'd1}) begin
      fails++;
      $display("FAIL seq_err_pulse got se=%b sticky=%b phase=%0d want se=0 sticky=1 phase=1", bus.seq_err, bus.err_sticky, bus.phase);
    end
    step(3'b001, 1'b1);
    tests++;
    if ({bus.err_sticky, bus.phase} !== {1'b0, 2'd2}) begin
      fails++;
      $display("FAIL sticky_clear got sticky=%b phase=%0d want sticky=0 phase=2", bus.err_sticky, bus.phase);
    end
  endtask

  task automatic test_illegal;
    step(3'b010, 1'b0);
    step(3'b100, 1'b0);
    tests++;
    if (bus.cycle_count !== 2'd0) begin
      fails++;
      $display("FAIL count_wrap4 got %0d want 0", bus.cycle_count);
    end
    step(3'b110, 1'b0);
    step(3'b111, 1'b0);
    tests++;
    if ({bus.illegal, bus.phase_valid, bus.phase, bus.seq_err, bus.err_sticky} !== {1'b1, 1'b0, 2'd1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL illegal_111 got il=%b v=%b phase=%0d se=%b sticky=%b want il=1 v=0 phase=1 se=0 sticky=1", bus.illegal, bus.phase_valid, bus.phase, bus.seq_err, bus.err_sticky);
    end
    step(3'b001, 1'b0);
    tests++;
    if ({bus.illegal, bus.phase_valid, bus.phase, bus.seq_err, bus.cycle_count} !== {1'b0, 1'b1, 2'd2, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL relock_green got il=%b v=%b phase=%0d se=%b cnt=%0d want il=0 v=1 phase=2 se=0 cnt=0", bus.illegal, bus.phase_valid, bus.phase, bus.seq_err, bus.cycle_count);
    end
  endtask

  task automatic test_clr_collision;
    step(3'b000, 1'b1);
    tests++;
    if ({bus.illegal, bus.err_sticky, bus.phase_valid} !== 3'b110) begin
      fails++;
      $display("FAIL clr_collision got il=%b sticky=%b v=%b want il=1 sticky=1 v=0", bus.illegal, bus.err_sticky, bus.phase_valid);
    end
    step(3'b100, 1'b1);
    tests++;
    if ({bus.err_sticky, bus.seq_err, bus.phase, bus.phase_valid} !== {1'b0, 1'b0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL clr_alone got sticky=%b se=%b phase=%0d v=%b want sticky=0 se=0 phase=0 v=1", bus.err_sticky, bus.seq_err, bus.phase, bus.phase_valid);
    end
  endtask

  task automatic test_dwell;
    step(3'b110, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(3'b001, 1'b0);
      tests++;
      if (bus.stuck !== (DWELL_EN && k >= 5)) begin
        fails++;
        $display("FAIL dwell_sample%0d got stuck=%b want %b", k, bus.stuck, DWELL_EN && k >= 5);
      end
    end
    step(3'b010, 1'b0);
    tests++;
    if ({bus.stuck, bus.phase, bus.seq_err} !== {1'b0, 2'd3, 1'b0}) begin
      fails++;
      $display("FAIL dwell_release got stuck=%b phase=%0d se=%b want stuck=0 phase=3 se=0", bus.stuck, bus.phase, bus.seq_err);
    end
  endtask

  task automatic test_wrap_and_async_reset;
    logic [2:0] pats [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) step(pats[i], 1'b0);
    tests++;
    if ({bus.cycle_count, bus.err_sticky} !== {2'd1, 1'b0}) begin
      fails++;
      $display("FAIL wrap_5_cycles got cnt=%0d sticky=%b want cnt=1 sticky=0", bus.cycle_count, bus.err_sticky);
    end
    step(3'b100, 1'b0);
    step(3'b110, 1'b0);
    step(3'b001, 1'b0);
    tests++;
    if ({bus.phase, bus.cycle_count} !== {2'd2, 2'd2}) begin
      fails++;
      $display("FAIL pre_reset got phase=%0d cnt=%0d want phase=2 cnt=2", bus.phase, bus.cycle_count);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, bus.err_sticky, bus.stuck, bus.cycle_count} !== 9'b0) begin
      fails++;
      $display("FAIL async_reset got %b want 000000000", {bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, bus.err_sticky, bus.stuck, bus.cycle_count});
    end
    @(negedge clk) rst = 1'b0;
    step(3'b010, 1'b0);
    tests++;
    if ({bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, bus.cycle_count} !== {2'd3, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL relock_after_reset got phase=%0d v=%b se=%b il=%b cnt=%0d want phase=3 v=1 se=0 il=0 cnt=0", bus.phase, bus.phase_valid, bus.seq_err, bus.illegal, bus.cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_seq_err();
    test_illegal();
    test_clr_collision();
    test_dwell();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
